mac_array_pipe: RTL and testbench

Multi-lane, framed dot-product accumulator for the 2D-convolution datapath.
- Each accepted beat multiplies LANES signed operand pairs, reduces them through a registered adder tree, and adds the sum into a frame accumulator.
- After acc_len beats, the frame result is presented on a valid/ready output.
- Sits between the window/kernel fetch logic and the output writeback; one instance computes one output pixel per frame.

---
 rtl/mac_pkg.sv | 41 ++++
 rtl/mac_add_tree.sv | 56 +++++
 rtl/mac_array_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_mac_array_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared types and helpers for the mac_array_pipe datapath.
// Revision : 1.0
// ============================================================================
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned MAX_W   = 128;
  localparam int unsigned MAX_BUS = 4096;

  // Narrowest result width that can hold a full-precision sum of all lanes.
  function automatic int min_outw(input int inw, input int lanes);
    return 2 * inw + $clog2(lanes);
  endfunction

  function automatic logic [MAX_W-1:0] lane_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int unsigned idx,
                                                  input int unsigned w);
    return MAX_W'(bus >> (idx * w));
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_signed(input logic signed [MAX_W-1:0] v,
                                                         input int unsigned w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (MAX_W'(1) <<< (w - 1)) - MAX_W'(1);
    lo = -hi - MAX_W'(1);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_add_tree.sv
`default_nettype none
// ============================================================================
// Module   : mac_add_tree
// Purpose  : One registered stage summing LANES signed products into OUTW bits.
// Revision : 1.0
// ============================================================================
module mac_add_tree
  import mac_pkg::*;
#(
  parameter int INW   = 16,
  parameter int OUTW  = 64,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [LANES*2*INW-1:0]   in_prod,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic signed [OUTW-1:0]   out_sum,
  output logic                     out_valid,
  output logic                     out_last
);

  localparam int PW = 2 * INW;

  logic signed [OUTW-1:0] sum_d, sum_q;
  logic                   valid_d, valid_q;
  logic                   last_d, last_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + OUTW'($signed(PW'(lane_slice(MAX_BUS'(in_prod), i, PW))));
    end
    valid_d = in_valid;
    last_d  = in_valid & in_last;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/mac_array_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_pipe
// Purpose  : Framed multi-lane signed dot-product accumulator with valid/ready
//            result handoff. MAC_ARRAY_SATURATE_EN enables saturating
//            accumulation and the sticky sat_flag output.
// Revision : 1.0
// ============================================================================
module mac_array_pipe
  import mac_pkg::*;
#(
  parameter int INW   = 16,
  parameter int OUTW  = 64,
  parameter int LANES = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CNTW-1:0]        acc_len,
  input  logic [OUTW-1:0]        init_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*INW-1:0]   in_a,
  input  logic [LANES*INW-1:0]   in_b,
  output logic [OUTW-1:0]        out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
`ifdef MAC_ARRAY_SATURATE_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int PW       = 2 * INW;
  localparam int OUTW_MIN = min_outw(INW, LANES);

  generate
    if (OUTW < OUTW_MIN) begin : g_outw_bad
      $error("mac_array_pipe: OUTW too small for INW/LANES");
    end
  endgenerate

  state_e state_d, state_q;

  logic [CNTW-1:0]        len_d, len_q;
  logic [CNTW-1:0]        cnt_d, cnt_q;
  logic signed [OUTW-1:0] acc_d, acc_q;
  logic [OUTW-1:0]        out_d, out_q;
  logic                   out_valid_d, out_valid_q;

  logic signed [INW-1:0]  a_lane [LANES];
  logic signed [INW-1:0]  b_lane [LANES];
  logic signed [INW-1:0]  a_d [LANES], a_q [LANES];
  logic signed [INW-1:0]  b_d [LANES], b_q [LANES];
  logic                   i_valid_d, i_valid_q, i_last_d, i_last_q;
  logic signed [PW-1:0]   prod_d [LANES], prod_q [LANES];
  logic                   p_valid_d, p_valid_q, p_last_d, p_last_q;
  logic [LANES*PW-1:0]    prod_bus;

  logic signed [OUTW-1:0] sum;
  logic                   sum_valid, sum_last;
  logic signed [OUTW-1:0] acc_next;
  logic                   accept, beat_last, handoff;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign a_lane[i] = INW'(lane_slice(MAX_BUS'(in_a), i, INW));
      assign b_lane[i] = INW'(lane_slice(MAX_BUS'(in_b), i, INW));
      assign prod_bus[i*PW +: PW] = prod_q[i];
    end
  endgenerate

  assign accept    = in_valid & in_ready;
  assign beat_last = (cnt_q == len_q - CNTW'(1));
  assign handoff   = out_valid_q & out_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)               state_d = ST_RUN;
      ST_RUN:   if (accept && beat_last) state_d = ST_DRAIN;
      ST_DRAIN: if (handoff)             state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered state only, never in_valid) ----------------
  always_comb begin
    in_ready = (state_q == ST_RUN);
    busy     = (state_q != ST_IDLE);
  end

  mac_add_tree #(
    .INW   (INW),
    .OUTW  (OUTW),
    .LANES (LANES)
  ) u_add_tree (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_prod   (prod_bus),
    .in_valid  (p_valid_q),
    .in_last   (p_last_q),
    .out_sum   (sum),
    .out_valid (sum_valid),
    .out_last  (sum_last)
  );

`ifdef MAC_ARRAY_SATURATE_EN
  logic signed [OUTW:0] acc_wide;
  logic                 acc_ovf;
  logic                 sat_d, sat_q;

  always_comb begin
    acc_wide = {acc_q[OUTW-1], acc_q} + {sum[OUTW-1], sum};
    acc_next = OUTW'(sat_signed(MAX_W'(acc_wide), OUTW));
    acc_ovf  = acc_wide[OUTW] ^ acc_wide[OUTW-1];
    sat_d    = sat_q;
    if (state_q == ST_IDLE && start) sat_d = 1'b0;
    else if (sum_valid && acc_ovf)   sat_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) sat_q <= 1'b0;
    else          sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  assign acc_next = acc_q + sum;
`endif

  // Datapath: operand capture, products, frame control and accumulation.
  always_comb begin
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    i_valid_d   = accept;
    i_last_d    = accept & beat_last;
    p_valid_d   = i_valid_q;
    p_last_d    = i_last_q;

    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = a_q[i] * b_q[i];
    end

    if (state_q == ST_IDLE && start) begin
      len_d = (acc_len == '0) ? CNTW'(1) : acc_len;
      acc_d = init_value;
      cnt_d = '0;
    end

    if (accept) begin
      cnt_d = cnt_q + CNTW'(1);
      a_d   = a_lane;
      b_d   = b_lane;
    end

    if (handoff) out_valid_d = 1'b0;

    if (sum_valid) begin
      acc_d = acc_next;
      if (sum_last) begin
        out_d       = acc_next;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      i_valid_q   <= 1'b0;
      i_last_q    <= 1'b0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      i_valid_q   <= i_valid_d;
      i_last_q    <= i_last_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_array_pipe
// Purpose  : Directed self-checking bench for mac_array_pipe (INW=16, OUTW=34, LANES=4).
// Revision : 1.0
// ============================================================================
module tb_mac_array_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] acc_len;
  logic [33:0] init_value;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [33:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef MAC_ARRAY_SATURATE_EN
  logic        sat_flag;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mac_array_pipe #(
    .INW   (16),
    .OUTW  (34),
    .LANES (4),
    .CNTW  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .acc_len    (acc_len),
    .init_value (init_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out        (dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef MAC_ARRAY_SATURATE_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input logic [33:0] init);
    start      = 1'b1;
    acc_len    = 16'(len);
    init_value = init;
    cyc();
    start      = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20 && !out_valid; k++) cyc();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    tests_run++; if (dout !== 34'd0)     begin tests_failed++; $display("FAIL reset_out: got %0h want 0", dout); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b0)  begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_start(1, 34'd10);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL single_run_ready: got %b want 1", in_ready); end
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL single_drain_ready: got %b want 0", in_ready); end
    cyc(); cyc();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    cyc();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency_valid: got %b want 1", out_valid); end
    tests_run++; if (dout !== 34'd80)    begin tests_failed++; $display("FAIL single_result: got %0d want 80", $signed(dout)); end
    handshake();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_clear_valid: got %b want 0", out_valid); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_gap();
    do_start(3, 34'd0);
    send_beat(pack4(-3, -3, -3, -3), pack4(7, 7, 7, 7));
    cyc(); cyc();
    send_beat(pack4(-3, -3, -3, -3), pack4(7, 7, 7, 7));
    send_beat(pack4(-3, -3, -3, -3), pack4(7, 7, 7, 7));
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL gap_ready_after_last: got %b want 0", in_ready); end
    wait_out();
    tests_run++; if (out_valid !== 1'b1)      begin tests_failed++; $display("FAIL gap_valid_timeout: got %b want 1", out_valid); end
    tests_run++; if (dout !== 34'(-252))      begin tests_failed++; $display("FAIL gap_result: got %0d want -252", $signed(dout)); end
    tests_run++; if (in_ready !== 1'b0)       begin tests_failed++; $display("FAIL gap_ready_wait: got %b want 0", in_ready); end
    handshake();
    tests_run++; if (busy !== 1'b0)           begin tests_failed++; $display("FAIL gap_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    do_start(1, 34'd0);
    send_beat(pack4(5, 0, 0, 0), pack4(5, 0, 0, 0));
    wait_out();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1; acc_len = 16'd1; init_value = 34'd999;
      end
      cyc();
      start = 1'b0;
      tests_run++; if (dout !== 34'd25 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold[%0d]: got out=%0d valid=%b want 25/1", k, $signed(dout), out_valid); end
      tests_run++; if (busy !== 1'b1 || in_ready !== 1'b0)    begin tests_failed++; $display("FAIL bp_busy[%0d]: got busy=%b ready=%b want 1/0", k, busy, in_ready); end
    end
    handshake();
    tests_run++; if (busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release: got busy=%b valid=%b want 0/0", busy, out_valid); end
    do_start(1, 34'd1);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_restart_ready: got %b want 1", in_ready); end
    send_beat(pack4(2, 0, 0, 0), pack4(3, 0, 0, 0));
    wait_out();
    tests_run++; if (dout !== 34'd7 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_restart_result: got %0d valid=%b want 7/1", $signed(dout), out_valid); end
    handshake();
  endtask

  task automatic test_len_zero();
    do_start(0, 34'(-5));
    send_beat(pack4(1, 0, 0, 0), pack4(2, 0, 0, 0));
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL len0_single_beat: got ready=%b want 0", in_ready); end
    wait_out();
    tests_run++; if (dout !== 34'(-3) || out_valid !== 1'b1) begin tests_failed++; $display("FAIL len0_result: got %0d valid=%b want -3/1", $signed(dout), out_valid); end
    handshake();
  endtask

  task automatic test_reset_mid();
    do_start(4, 34'd100);
    send_beat(pack4(1, 1, 1, 1), pack4(9, 9, 9, 9));
    send_beat(pack4(1, 1, 1, 1), pack4(9, 9, 9, 9));
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    tests_run++; if (dout !== 34'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out: got out=%0d valid=%b want 0/0", $signed(dout), out_valid); end
    tests_run++; if (busy !== 1'b0 || in_ready !== 1'b0)   begin tests_failed++; $display("FAIL midrst_ctrl: got busy=%b ready=%b want 0/0", busy, in_ready); end
    cyc(); cyc(); cyc(); cyc();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_flush: got valid=%b want 0", out_valid); end
    do_start(1, 34'd0);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    wait_out();
    tests_run++; if (dout !== 34'd4 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_fresh: got %0d valid=%b want 4/1", $signed(dout), out_valid); end
    handshake();
  endtask

  task automatic test_saturate();
    logic [33:0] max_v;
    logic [33:0] exp_v;
    max_v = {1'b0, {33{1'b1}}};
`ifdef MAC_ARRAY_SATURATE_EN
    exp_v = max_v;
`else
    exp_v = max_v + 34'd10000;
`endif
    do_start(1, max_v);
    send_beat(pack4(100, 0, 0, 0), pack4(100, 0, 0, 0));
    wait_out();
    tests_run++; if (dout !== exp_v || out_valid !== 1'b1) begin tests_failed++; $display("FAIL overflow_result: got %0h valid=%b want %0h/1", dout, out_valid, exp_v); end
`ifdef MAC_ARRAY_SATURATE_EN
    tests_run++; if (sat_flag !== 1'b1) begin tests_failed++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
`endif
    handshake();
    do_start(1, 34'd0);
`ifdef MAC_ARRAY_SATURATE_EN
    tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
`endif
    send_beat(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
    wait_out();
    tests_run++; if (dout !== 34'd0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL overflow_followup: got %0h valid=%b want 0/1", dout, out_valid); end
    handshake();
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    acc_len    = '0;
    init_value = '0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;

    test_reset();
    test_single();
    test_gap();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    test_saturate();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
